// File: rtl/aes_serial_seq.sv
// aes_serial_seq: request sequencer for the serial AES-128 core.
// Accepts one encrypt/decrypt request at a time, registers the operands,
// pulses core_start, follows the core_ready low-then-high handshake and
// returns result, latency and error on a valid/ready output stream.
// Optional watchdog abort: define AES_SEQ_WATCHDOG_EN.
module aes_serial_seq #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_enc_dec,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         core_start,
  output logic         core_enc_dec,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key_in,
  input  logic [127:0] core_data_out,
  input  logic         core_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err,
  output logic [15:0]  out_cycles
);

`ifdef AES_SEQ_WATCHDOG_EN
  localparam bit LP_WD_EN = 1'b1;
`else
  localparam bit LP_WD_EN = 1'b0;
`endif

  localparam logic [31:0] LP_TIMEOUT   = 32'(TIMEOUT_CYCLES);
  // Reported latency on abort; a limit beyond the 16-bit counter range can
  // never be reached, so such a build simply waits without bound.
  localparam logic [15:0] LP_TO_REPORT = (LP_TIMEOUT > 32'h0000_FFFF) ? 16'hFFFF : LP_TIMEOUT[15:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_OUT
  } state_t;

  state_t         r_state;
  logic           r_core_start;
  logic           r_core_enc_dec;
  logic [127:0]   r_core_data_in;
  logic [127:0]   r_core_key_in;
  logic [15:0]    r_cnt;
  logic           r_out_valid;
  logic [127:0]   r_out_data;
  logic           r_out_err;
  logic [15:0]    r_out_cycles;

  logic [15:0]    w_cnt_next;
  logic           w_timeout;
  logic           w_accept;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_cnt_next = sat_inc16(r_cnt);
  // Abort once the count of wait cycles (including this one) hits the limit.
  assign w_timeout  = LP_WD_EN && ({16'd0, w_cnt_next} >= LP_TIMEOUT);
  assign w_accept   = in_valid && in_ready;

  // Only one request in flight: accept solely in IDLE with the core idle.
  assign in_ready     = (r_state == S_IDLE) && core_ready;
  assign core_start   = r_core_start;
  assign core_enc_dec = r_core_enc_dec;
  assign core_data_in = r_core_data_in;
  assign core_key_in  = r_core_key_in;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_err      = r_out_err;
  assign out_cycles   = r_out_cycles;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_core_start   <= 1'b0;
      r_core_enc_dec <= 1'b0;
      r_core_data_in <= '0;
      r_core_key_in  <= '0;
      r_cnt          <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_err      <= 1'b0;
      r_out_cycles   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_core_enc_dec <= in_enc_dec;
            r_core_data_in <= in_data;
            r_core_key_in  <= in_key;
            // Raised here so the pulse occupies exactly the START cycle.
            r_core_start   <= 1'b1;
            r_state        <= S_START;
          end
        end
        S_START: begin
          r_core_start <= 1'b0;
          r_cnt        <= '0;
          r_state      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          r_cnt <= w_cnt_next;
          if (!core_ready) begin
            r_state <= S_WAIT_DONE;
          end else if (w_timeout) begin
            r_out_data   <= '0;
            r_out_err    <= 1'b1;
            r_out_cycles <= LP_TO_REPORT;
            r_out_valid  <= 1'b1;
            r_state      <= S_OUT;
          end
        end
        S_WAIT_DONE: begin
          r_cnt <= w_cnt_next;
          if (core_ready) begin
            r_out_data   <= core_data_out;
            r_out_err    <= 1'b0;
            r_out_cycles <= w_cnt_next;
            r_out_valid  <= 1'b1;
            r_state      <= S_OUT;
          end else if (w_timeout) begin
            r_out_data   <= '0;
            r_out_err    <= 1'b1;
            r_out_cycles <= LP_TO_REPORT;
            r_out_valid  <= 1'b1;
            r_state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_core_start <= 1'b0;
          r_out_valid  <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_serial_seq.sv
// Self-checking bench for aes_serial_seq. A behavioural stand-in for the
// serial AES core answers known-answer vectors after a programmable busy
// time; it can also be told never to drop core_ready.
module tb_aes_serial_seq;

  localparam int TO = 50;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_AB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_AB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_AB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_enc_dec;
  logic [127:0] in_data, in_key;
  logic         core_start, core_enc_dec;
  logic [127:0] core_data_in, core_key_in, core_data_out;
  logic         core_ready;
  logic         out_valid, out_ready, out_err;
  logic [127:0] out_data;
  logic [15:0]  out_cycles;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_serial_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_enc_dec(in_enc_dec),
    .in_data(in_data), .in_key(in_key),
    .core_start(core_start), .core_enc_dec(core_enc_dec),
    .core_data_in(core_data_in), .core_key_in(core_key_in),
    .core_data_out(core_data_out), .core_ready(core_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_cycles(out_cycles)
  );

  // ---------------- core stand-in ----------------
  int   stub_lat = 4;
  logic stub_stuck = 1'b0;
  int   busy;

  function automatic logic [127:0] stub_aes(input logic enc, input logic [127:0] key, input logic [127:0] data);
    if (enc && key == K_C1 && data == P_C1) return C_C1;
    if (!enc && key == K_AB && data == C_AB) return P_AB;
    if (enc && key == '0 && data == '0) return C_Z;
    if (!enc && key == '0 && data == C_Z) return '0;
    return 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  endfunction

  // Ready drops for stub_lat cycles after the start pulse is sampled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready    <= 1'b1;
      core_data_out <= '0;
      busy          <= 0;
    end else if (core_start && !stub_stuck) begin
      core_ready <= 1'b0;
      busy       <= stub_lat;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        core_ready    <= 1'b1;
        core_data_out <= stub_aes(core_enc_dec, core_key_in, core_data_in);
      end
    end
  end

  // ---------------- monitors ----------------
  int           start_cnt = 0;
  int           inr_viol = 0;
  int           opd_viol = 0;
  logic         busy_phase = 1'b0;
  logic         cur_enc;
  logic [127:0] cur_data, cur_key;

  always @(posedge clk) if (rst_n && core_start) start_cnt++;

  always @(negedge clk) begin
    if (busy_phase) begin
      if (in_ready) inr_viol++;
      if (core_data_in !== cur_data || core_key_in !== cur_key || core_enc_dec !== cur_enc) opd_viol++;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete request: accept, wait for result, optional stall, handshake.
  task automatic run_req(input string tag, input logic enc, input logic [127:0] data,
                         input logic [127:0] key, input logic [127:0] exp, input int lat, input int stall);
    int edges, s0, v0, o0, unstable;
    logic [127:0] hd;
    logic [15:0]  hc;
    @(negedge clk);
    stub_lat = lat;
    in_enc_dec = enc; in_data = data; in_key = key; in_valid = 1'b1;
    cur_enc = enc; cur_data = data; cur_key = key;
    #1 chk({tag, " in_ready_idle"}, 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_phase = 1'b1;
    s0 = start_cnt; v0 = inr_viol; o0 = opd_viol;
    edges = 0;
    while (!out_valid && edges < 500) begin
      @(posedge clk); #1;
      edges++;
    end
    // Accept cycle to first out_valid cycle spans lat + 3 cycles.
    chk({tag, " out_valid"}, 128'(out_valid), 128'(1));
    chk({tag, " latency_edges"}, 128'(edges), 128'(lat + 2));
    chk({tag, " out_data"}, out_data, exp);
    chk({tag, " out_err"}, 128'(out_err), 128'(0));
    chk({tag, " out_cycles"}, 128'(out_cycles), 128'(lat + 1));
    chk({tag, " start_pulses"}, 128'(start_cnt - s0), 128'(1));
    hd = out_data; hc = out_cycles; unstable = 0;
    repeat (stall) begin
      @(negedge clk);
      if (!out_valid || out_data !== hd || out_cycles !== hc || out_err !== 1'b0 || in_ready) unstable++;
    end
    if (stall > 0) chk({tag, " stall_unstable"}, 128'(unstable), 128'(0));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    busy_phase = 1'b0;
    chk({tag, " out_valid_after_hs"}, 128'(out_valid), 128'(0));
    chk({tag, " in_ready_busy_viol"}, 128'(inr_viol - v0), 128'(0));
    chk({tag, " operand_viol"}, 128'(opd_viol - o0), 128'(0));
  endtask

  typedef struct {
    logic         enc;
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] exp;
    int           lat;
    int           stall;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int edges, seen;
    vecs[0] = '{enc: 1'b1, data: P_C1, key: K_C1, exp: C_C1, lat: 8,  stall: 0};
    vecs[1] = '{enc: 1'b0, data: C_AB, key: K_AB, exp: P_AB, lat: 5,  stall: 0};
    vecs[2] = '{enc: 1'b1, data: '0,   key: '0,   exp: C_Z,  lat: 1,  stall: 20};
    vecs[3] = '{enc: 1'b0, data: C_Z,  key: '0,   exp: '0,   lat: 3,  stall: 20};

    rst_n = 1'b0; in_valid = 1'b0; in_enc_dec = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 128'(in_ready), 128'(1));
    chk("rst core_start", 128'(core_start), 128'(0));
    chk("rst core_regs", core_data_in | core_key_in | 128'(core_enc_dec), '0);
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst out_data", out_data, '0);
    chk("rst out_err_cycles", {out_cycles, 7'd0, out_err}, '0);
    @(negedge clk); rst_n = 1'b1;

    // Idle with in_valid low: nothing happens.
    repeat (10) @(negedge clk);
    chk("idle start_pulses", 128'(start_cnt), 128'(0));
    chk("idle in_ready", 128'(in_ready), 128'(1));

    // Table: C.1, Appendix B, then back-to-back zero encrypt/decrypt with stalls.
    for (int i = 0; i < 4; i++)
      run_req($sformatf("vec%0d", i), vecs[i].enc, vecs[i].data, vecs[i].key, vecs[i].exp, vecs[i].lat, vecs[i].stall);

    // Reset while waiting for the core.
    @(negedge clk);
    stub_lat = 30; in_enc_dec = 1'b1; in_data = P_C1; in_key = K_C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("mid core_data_in", core_data_in, P_C1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst core_regs", core_data_in | core_key_in | 128'(core_enc_dec), '0);
    chk("mid_rst core_start", 128'(core_start), 128'(0));
    chk("mid_rst out_err_cycles", {out_cycles, 7'd0, out_err}, '0);
    chk("mid_rst in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("post_rst no_out_valid", 128'(seen), 128'(0));
    run_req("c1_after_rst", 1'b1, P_C1, K_C1, C_C1, 8, 0);

    // Core that never drops ready.
    stub_stuck = 1'b1;
    @(negedge clk);
    in_enc_dec = 1'b1; in_data = P_C1; in_key = K_C1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = start_cnt;
`ifdef AES_SEQ_WATCHDOG_EN
    edges = 0;
    while (!out_valid && edges < 200) begin @(posedge clk); #1; edges++; end
    chk("wd out_valid", 128'(out_valid), 128'(1));
    chk("wd out_err", 128'(out_err), 128'(1));
    chk("wd out_data", out_data, '0);
    chk("wd out_cycles", 128'(out_cycles), 128'(TO));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    stub_stuck = 1'b0;
    run_req("after_wd", 1'b0, C_AB, K_AB, P_AB, 6, 0);
`else
    edges = 0;
    repeat (100) begin @(negedge clk); if (out_valid) edges++; end
    chk("stuck no_out_valid", 128'(edges), 128'(0));
    chk("stuck in_ready", 128'(in_ready), 128'(0));
    chk("stuck start_pulses", 128'(start_cnt - seen), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stub_stuck = 1'b0;
    run_req("after_stuck", 1'b1, P_C1, K_C1, C_C1, 4, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
